// File: rtl/u409_cia_cycle.sv
// u409_cia_cycle: 8520 CIA E-clock generator and 6800-style bus cycle sequencer for CIA-space 68040 accesses
module u409_cia_cycle #(
  parameter int E_LOW  = 34,
  parameter int E_HIGH = 22
) (
  input  logic CLK40,
  input  logic RESET,
  input  logic TSn,
  input  logic CIA_SPACE,
  input  logic RnW,
  output logic E,
  output logic CIA_ENABLE,
  output logic DATA_LATCH,
  output logic TACKn,
  output logic CIA_BUSY
);
  localparam int E_PERIOD = E_LOW + E_HIGH;
  localparam int W = $clog2(E_PERIOD);
  localparam logic [W-1:0] LAST = W'(E_PERIOD - 1);
  localparam logic [W-1:0] ELOW = W'(E_LOW);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_TERM} state_t;
  state_t state, state_nxt;
  logic [W-1:0] ecnt, ecnt_nxt;
  logic rd, rd_nxt, accept, wrap;
  always_comb begin
    wrap = ecnt == LAST;
    ecnt_nxt = wrap ? '0 : ecnt + W'(1);
    accept = state == S_IDLE && !TSn && CIA_SPACE;
    rd_nxt = accept ? RnW : rd;
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = accept ? (wrap ? S_ACTIVE : S_WAIT) : S_IDLE;
      S_WAIT:   state_nxt = wrap ? S_ACTIVE : S_WAIT;
      S_ACTIVE: state_nxt = wrap ? S_TERM : S_ACTIVE;
      S_TERM:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end
  // Outputs are registered from next-state values so they line up with ECNT without lag
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state <= S_IDLE;
      ecnt <= '0;
      rd <= 1'b0;
      E <= 1'b0;
      CIA_ENABLE <= 1'b0;
      DATA_LATCH <= 1'b0;
      TACKn <= 1'b1;
      CIA_BUSY <= 1'b0;
    end else begin
      state <= state_nxt;
      ecnt <= ecnt_nxt;
      rd <= rd_nxt;
      E <= ecnt_nxt >= ELOW;
      CIA_ENABLE <= state_nxt == S_ACTIVE;
      DATA_LATCH <= state_nxt == S_ACTIVE && ecnt_nxt == LAST && rd_nxt;
      TACKn <= state_nxt != S_TERM;
      CIA_BUSY <= state_nxt != S_IDLE;
    end
  end
endmodule

// File: tb/tb_u409_cia_cycle.sv
// tb_u409_cia_cycle: directed scoreboard bench for the CIA cycle sequencer
module tb_u409_cia_cycle;
  logic CLK40 = 1'b0, RESET, TSn, CIA_SPACE, RnW;
  logic E, CIA_ENABLE, DATA_LATCH, TACKn, CIA_BUSY;
  typedef struct {int tack; bit rd;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  int cyc = 0, m_ecnt = 0, lat_cnt = 0;
  bit pend = 0, t_rd = 0;
  int t_acc = 0, t_tack = 0;

  u409_cia_cycle dut (
    .CLK40(CLK40), .RESET(RESET), .TSn(TSn), .CIA_SPACE(CIA_SPACE), .RnW(RnW),
    .E(E), .CIA_ENABLE(CIA_ENABLE), .DATA_LATCH(DATA_LATCH), .TACKn(TACKn), .CIA_BUSY(CIA_BUSY)
  );

  always #5 CLK40 = ~CLK40;

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    bit r;
    exp_t e;
    r = RESET;
    @(posedge CLK40);
    #1;
    cyc++;
    if (r) begin
      m_ecnt = 0;
      pend = 0;
      lat_cnt = 0;
      sb.delete();
    end else m_ecnt = (m_ecnt + 1) % 56;
    if (pend && cyc > t_tack) pend = 0;
    chk("E", E, m_ecnt >= 34);
    chk("CIA_ENABLE", CIA_ENABLE, pend && cyc >= t_tack - 56 && cyc < t_tack);
    chk("CIA_BUSY", CIA_BUSY, pend && cyc >= t_acc && cyc <= t_tack);
    chk("DATA_LATCH", DATA_LATCH, pend && t_rd && cyc == t_tack - 1);
    chk("TACKn", TACKn, !(pend && cyc == t_tack));
    if (DATA_LATCH === 1'b1) lat_cnt++;
    if (TACKn === 1'b0) begin
      if (sb.size() == 0) chk_int("unexpected_tack", 1, 0);
      else begin
        e = sb.pop_front();
        chk_int("tack_cycle", cyc, e.tack);
        chk_int("latch_count", lat_cnt, e.rd ? 1 : 0);
        lat_cnt = 0;
      end
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic align(int v);
    for (int i = 0; i < 60 && m_ecnt != v; i++) tick();
  endtask

  // Acceptance edge is the next one; ECNT seen there is the current m_ecnt
  task automatic access(bit rnw, bit space);
    if (!pend && space) begin
      pend = 1;
      t_acc = cyc + 1;
      t_tack = t_acc + 111 - m_ecnt;
      t_rd = rnw;
      sb.push_back('{t_tack, rnw});
    end
    TSn = 1'b0;
    CIA_SPACE = space;
    RnW = rnw;
    tick();
    TSn = 1'b1;
  endtask

  initial begin
    RESET = 1'b1;
    TSn = 1'b1;
    CIA_SPACE = 1'b0;
    RnW = 1'b1;
    run(3);
    RESET = 1'b0;
    run(120);
    align(10);
    access(1'b1, 1'b1);
    CIA_SPACE = 1'b0;
    run(115);
    align(55);
    access(1'b0, 1'b1);
    run(70);
    access(1'b1, 1'b0);
    run(5);
    access(1'b0, 1'b0);
    run(5);
    align(20);
    access(1'b1, 1'b1);
    run(10);
    access(1'b0, 1'b1);
    for (int i = 0; i < 200 && cyc < t_tack - 40; i++) tick();
    access(1'b0, 1'b1);
    for (int i = 0; i < 200 && cyc < t_tack; i++) tick();
    access(1'b0, 1'b1);
    access(1'b1, 1'b1);
    run(130);
    access(1'b1, 1'b1);
    for (int i = 0; i < 200 && !(pend && cyc >= t_tack - 56 && m_ecnt == 30); i++) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    run(120);
    chk_int("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
